// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access stage: turns MEM-stage loads/stores into a req/ack bus
// transaction and stalls the pipeline until the access completes or times out.
module mem_access_unit #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [31:0] Memory_Address,
    input  logic [31:0] Write_Data_Memory,
    output logic [31:0] Read_Data_Memory,
    output logic        Mem_Stall,
    output logic        Align_Error,
    output logic        Bus_Error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            timeout_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;

    logic access;
    logic aligned;
    logic start;

    assign access  = Mem_Read | Mem_Write;
    assign aligned = (Memory_Address[1:0] == 2'b00);
    assign start   = (state_q == StIdle) && access && aligned;

    // Combinational outputs are forced low while reset is held, even if a request is pending.
    assign Mem_Stall   = rst_n && (start || (state_q == StReq));
    assign Align_Error = rst_n && (state_q == StIdle) && access && !aligned;
    assign Bus_Error   = rst_n && (state_q == StDone) && timeout_q;

    assign bus_req          = req_q;
    assign bus_we           = we_q;
    assign bus_addr         = addr_q;
    assign bus_wdata        = wdata_q;
    assign Read_Data_Memory = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        req_q     <= 1'b1;
                        we_q      <= Mem_Write;  // write wins when both are set
                        addr_q    <= {Memory_Address[31:2], 2'b00};
                        wdata_q   <= Write_Data_Memory;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= bus_rdata;
                        end
                        state_q <= StDone;
                    end else if (cnt_q == CntMax) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= ERR_DATA;
                        end
                        timeout_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    // Inputs still show the finished instruction here; never re-issue it.
                    timeout_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a bus responder driven per access, expected load
// data queued at stimulus time and compared when the access reaches its DONE cycle.
module tb_mem_access_unit;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Mem_Read = 1'b0;
    logic        Mem_Write = 1'b0;
    logic [31:0] Memory_Address = '0;
    logic [31:0] Write_Data_Memory = '0;
    logic [31:0] Read_Data_Memory;
    logic        Mem_Stall;
    logic        Align_Error;
    logic        Bus_Error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    mem_access_unit #(
        .TIMEOUT (TO),
        .ERR_DATA(ERR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Mem_Read         (Mem_Read),
        .Mem_Write        (Mem_Write),
        .Memory_Address   (Memory_Address),
        .Write_Data_Memory(Write_Data_Memory),
        .Read_Data_Memory (Read_Data_Memory),
        .Mem_Stall        (Mem_Stall),
        .Align_Error      (Align_Error),
        .Bus_Error        (Bus_Error),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdm = '0;
    logic [31:0] exp_v;

    // Results of the most recent run_access call
    int          r_stall;
    int          r_req_edges;
    logic        r_req_first;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_rdm;
    logic        r_berr;
    logic        r_hung;

    // Drives one access starting in an IDLE cycle and plays the memory side.
    // ack_at = REQ cycle (1-based) in which bus_ack is returned, 0 = never.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_at,
                              input logic [31:0] rdata);
        int   req_cyc;
        logic prev_req;
        r_stall = 0; r_req_edges = 0; r_hung = 1'b1; r_berr = 1'b0;
        r_addr = '0; r_we = 1'b0; r_wdata = '0; r_rdm = '0;
        req_cyc = 0; prev_req = 1'b0;
        @(negedge clk);
        Mem_Read = rd; Mem_Write = wr; Memory_Address = addr; Write_Data_Memory = wdata;
        #1;
        r_req_first = bus_req;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (bus_req && !prev_req) r_req_edges++;
            prev_req = bus_req;
            if (Mem_Stall) r_stall++;
            if (bus_req) begin
                req_cyc++;
                r_addr = bus_addr; r_we = bus_we; r_wdata = bus_wdata;
                bus_ack   = (req_cyc == ack_at);
                bus_rdata = (req_cyc == ack_at) ? rdata : 32'h0BAD_0000;
            end else if (!Mem_Stall && r_stall > 0) begin
                r_rdm  = Read_Data_Memory;
                r_berr = Bus_Error;
                bus_ack = 1'b0;
                r_hung = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        Mem_Read = 1'b0; Mem_Write = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus_req, bus_we, Mem_Stall, Align_Error, Bus_Error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {bus_req, bus_we, Mem_Stall, Align_Error, Bus_Error});
        end
        checks++;
        if ({bus_addr, bus_wdata, Read_Data_Memory} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", bus_addr, bus_wdata,
                     Read_Data_Memory);
        end
        rst_n = 1'b1;
        model_rdm = '0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus_req, Mem_Stall} !== 2'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want 00", {bus_req, Mem_Stall});
        end
    endtask

    task automatic test_load();
        model_rdm = 32'hCAFE_0001;
        exp_q.push_back(model_rdm);
        run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hCAFE_0001);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_hung !== 1'b0) begin errors++; $display("FAIL load_done got hung want done"); end
        checks++;
        if (r_stall != 4) begin errors++; $display("FAIL load_stall got %0d want 4", r_stall); end
        checks++;
        if (r_req_edges != 1 || r_req_first !== 1'b0) begin
            errors++;
            $display("FAIL load_req got %0d/%b want 1/0", r_req_edges, r_req_first);
        end
        checks++;
        if (r_addr !== 32'h40 || r_we !== 1'b0) begin
            errors++;
            $display("FAIL load_bus got %h we=%b want 00000040 we=0", r_addr, r_we);
        end
        checks++;
        if (r_rdm !== exp_v || r_berr !== 1'b0) begin
            errors++;
            $display("FAIL load_data got %h berr=%b want %h berr=0", r_rdm, r_berr, exp_v);
        end
    endtask

    task automatic test_store();
        exp_q.push_back(model_rdm);
        run_access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 1, 32'hFFFF_EEEE);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_stall != 2 || r_hung !== 1'b0) begin
            errors++;
            $display("FAIL store_stall got %0d hung=%b want 2", r_stall, r_hung);
        end
        checks++;
        if (r_we !== 1'b1 || r_wdata !== 32'h1234_5678 || r_addr !== 32'h100) begin
            errors++;
            $display("FAIL store_bus got we=%b %h @%h want we=1 12345678 @00000100",
                     r_we, r_wdata, r_addr);
        end
        checks++;
        if (r_rdm !== exp_v) begin
            errors++;
            $display("FAIL store_rdm got %h want %h", r_rdm, exp_v);
        end
        // Both controls asserted: must be treated as a store
        exp_q.push_back(model_rdm);
        run_access(1'b1, 1'b1, 32'h0000_0104, 32'hA5A5_5A5A, 1, 32'h7777_7777);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_we !== 1'b1 || r_wdata !== 32'hA5A5_5A5A || r_rdm !== exp_v) begin
            errors++;
            $display("FAIL write_priority got we=%b %h rdm=%h want we=1 a5a55a5a rdm=%h",
                     r_we, r_wdata, r_rdm, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        model_rdm = 32'hA5A5_0010;
        exp_q.push_back(model_rdm);
        run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hA5A5_0010);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_req_edges != 1 || r_addr !== 32'h10 || r_rdm !== exp_v || r_stall != 2) begin
            errors++;
            $display("FAIL b2b_load got req=%0d @%h rdm=%h stall=%0d want 1 @10 %h 2",
                     r_req_edges, r_addr, r_rdm, r_stall, exp_v);
        end
        exp_q.push_back(model_rdm);
        run_access(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_0014, 1, 32'h0);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_req_first !== 1'b0 || r_req_edges != 1) begin
            errors++;
            $display("FAIL b2b_reissue got first=%b edges=%0d want 0 1", r_req_first,
                     r_req_edges);
        end
        checks++;
        if (r_addr !== 32'h14 || r_we !== 1'b1 || r_wdata !== 32'hDEAD_0014
            || r_rdm !== exp_v) begin
            errors++;
            $display("FAIL b2b_store got @%h we=%b %h rdm=%h want @14 we=1 dead0014 rdm=%h",
                     r_addr, r_we, r_wdata, r_rdm, exp_v);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        Mem_Read = 1'b1; Memory_Address = 32'h0000_0042;
        #1;
        checks++;
        if (Align_Error !== 1'b1 || Mem_Stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse got ae=%b stall=%b want 1 0", Align_Error, Mem_Stall);
        end
        @(posedge clk);
        #1;
        Mem_Read = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || Align_Error !== 1'b0 || Read_Data_Memory !== model_rdm) begin
            errors++;
            $display("FAIL misalign_after got req=%b ae=%b rdm=%h want 0 0 %h",
                     bus_req, Align_Error, Read_Data_Memory, model_rdm);
        end
    endtask

    task automatic test_timeout();
        model_rdm = ERR;
        exp_q.push_back(model_rdm);
        run_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h0);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_stall != TO + 1 || r_hung !== 1'b0) begin
            errors++;
            $display("FAIL timeout_stall got %0d hung=%b want %0d", r_stall, r_hung, TO + 1);
        end
        checks++;
        if (r_berr !== 1'b1 || r_rdm !== exp_v) begin
            errors++;
            $display("FAIL timeout_err got berr=%b rdm=%h want 1 %h", r_berr, r_rdm, exp_v);
        end
        checks++;
        if (Bus_Error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse got %b want 0 after DONE", Bus_Error);
        end
        repeat (2) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h1A7E_1A7E;
        #1;
        checks++;
        if (bus_req !== 1'b0 || Mem_Stall !== 1'b0) begin
            errors++;
            $display("FAIL late_ack got req=%b stall=%b want 0 0", bus_req, Mem_Stall);
        end
        @(negedge clk);
        #1;
        bus_ack = 1'b0;
        checks++;
        if (Bus_Error !== 1'b0 || bus_req !== 1'b0 || Read_Data_Memory !== model_rdm) begin
            errors++;
            $display("FAIL late_ack_state got berr=%b req=%b rdm=%h want 0 0 %h",
                     Bus_Error, bus_req, Read_Data_Memory, model_rdm);
        end
        model_rdm = 32'h600D_0090;
        exp_q.push_back(model_rdm);
        run_access(1'b1, 1'b0, 32'h0000_0090, 32'h0, 2, 32'h600D_0090);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_berr !== 1'b0 || r_rdm !== exp_v || r_stall != 3) begin
            errors++;
            $display("FAIL post_timeout got berr=%b rdm=%h stall=%0d want 0 %h 3",
                     r_berr, r_rdm, r_stall, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        Mem_Read = 1'b1; Memory_Address = 32'h0000_0200;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1 || Mem_Stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got req=%b stall=%b want 1 1", bus_req, Mem_Stall);
        end
        rst_n = 1'b0;
        #1;
        model_rdm = '0;
        checks++;
        if ({bus_req, bus_we, Mem_Stall, Align_Error, Bus_Error} !== 5'b0
            || bus_addr !== 32'h0 || Read_Data_Memory !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got ctrl=%b addr=%h rdm=%h want 0 0 0",
                     {bus_req, bus_we, Mem_Stall, Align_Error, Bus_Error}, bus_addr,
                     Read_Data_Memory);
        end
        Mem_Read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_rdm = 32'h5EED_0300;
        exp_q.push_back(model_rdm);
        run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 2, 32'h5EED_0300);
        exp_v = exp_q.pop_front();
        checks++;
        if (r_hung !== 1'b0 || r_stall != 3 || r_rdm !== exp_v || r_addr !== 32'h300) begin
            errors++;
            $display("FAIL mid_recover got hung=%b stall=%0d rdm=%h @%h want 0 3 %h @300",
                     r_hung, r_stall, r_rdm, r_addr, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
